// File: rtl/vx_fpu_arb_pkg.sv
// Shared FPU request/response layouts and width constants for the FPU arbiter slice.
package VX_fpu_types;

   localparam int FPU_REQ_DATAW = 128;
   localparam int FPU_RSP_DATAW = 40;

   typedef struct packed {
      logic [22:0] rsvd;
      logic [3:0]  op_type;
      logic [1:0]  fmt;
      logic [2:0]  frm;
      logic [31:0] dataa;
      logic [31:0] datab;
      logic [31:0] datac;
   } fpu_req_t;

   typedef struct packed {
      logic [1:0]  rsvd;
      logic [31:0] result;
      logic        has_fflags;
      logic [4:0]  fflags;
   } fpu_rsp_t;

   // Requester index width; a single requester still carries a 1-bit index.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_fpu_arb_skid_buf.sv
// 2-entry registered buffer: output is always a register, ready_o depends only on occupancy.
module VX_fpu_skid_buf #(
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [DATAW-1:0] data_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [DATAW-1:0] data_o,
   input  logic             ready_i
);

   logic [1:0][DATAW-1:0] mem_q;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  push, pop;

   assign ready_o = !reset && (cnt_q != 2'd2);
   assign valid_o = !reset && (cnt_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = !wr_ptr_q;
      if (pop)  rd_ptr_d = !rd_ptr_q;
      if (push && !pop)      cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/vx_fpu_arb.sv
// Round-robin arbiter sharing one FPU among NUM_REQS requesters; responses routed back by
// the requester index carried in the upper tag bits.
module vx_fpu_arb
   import VX_fpu_types::*;
#(
   parameter int NUM_REQS  = 4,
   parameter int REQ_DATAW = FPU_REQ_DATAW,
   parameter int RSP_DATAW = FPU_RSP_DATAW,
   parameter int TAG_WIDTH = 8,
   localparam int SELW     = sel_w(NUM_REQS)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQS-1:0]                  req_valid,
   input  logic [NUM_REQS-1:0][REQ_DATAW-1:0]   req_data,
   input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag,
   output logic [NUM_REQS-1:0]                  req_ready,
   output logic                                 fpu_req_valid,
   output logic [REQ_DATAW-1:0]                 fpu_req_data,
   output logic [TAG_WIDTH+SELW-1:0]            fpu_req_tag,
   input  logic                                 fpu_req_ready,
   input  logic                                 fpu_rsp_valid,
   input  logic [RSP_DATAW-1:0]                 fpu_rsp_data,
   input  logic [TAG_WIDTH+SELW-1:0]            fpu_rsp_tag,
   output logic                                 fpu_rsp_ready,
   output logic [NUM_REQS-1:0]                  rsp_valid,
   output logic [NUM_REQS-1:0][RSP_DATAW-1:0]   rsp_data,
   output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   rsp_tag,
   input  logic [NUM_REQS-1:0]                  rsp_ready
);

   localparam int RQW = SELW + TAG_WIDTH + REQ_DATAW;
   localparam int RSW = SELW + TAG_WIDTH + RSP_DATAW;

   logic [SELW-1:0] rr_q, rr_d;
   logic [SELW-1:0] gnt_idx, cand;
   logic            gnt_vld, req_fire, req_skid_rdy;

   // Walk from farthest to nearest so the entry just after rr_q wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = NUM_REQS; i >= 1; i--) begin
         cand = SELW'((int'(rr_q) + i) % NUM_REQS);
         if (req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign req_fire = gnt_vld && req_skid_rdy;
   assign rr_d     = req_fire ? gnt_idx : rr_q;

   always_comb begin
      req_ready          = '0;
      req_ready[gnt_idx] = req_fire;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_q <= SELW'(NUM_REQS - 1);
      else       rr_q <= rr_d;
   end

   VX_fpu_skid_buf #(.DATAW(RQW)) u_req_buf (
      .clk     (clk),
      .reset   (reset),
      .valid_i (gnt_vld),
      .data_i  ({gnt_idx, req_tag[gnt_idx], req_data[gnt_idx]}),
      .ready_o (req_skid_rdy),
      .valid_o (fpu_req_valid),
      .data_o  ({fpu_req_tag, fpu_req_data}),
      .ready_i (fpu_req_ready)
   );

   logic [SELW-1:0]      in_idx, o_idx;
   logic [TAG_WIDTH-1:0] o_tag;
   logic [RSP_DATAW-1:0] o_data;
   logic                 idx_ok, o_vld, o_rdy;

   assign in_idx = fpu_rsp_tag[TAG_WIDTH +: SELW];
   assign idx_ok = int'(in_idx) < NUM_REQS;

   // Out-of-range indices still handshake on the FPU side but never enter the buffer.
   VX_fpu_skid_buf #(.DATAW(RSW)) u_rsp_buf (
      .clk     (clk),
      .reset   (reset),
      .valid_i (fpu_rsp_valid && idx_ok),
      .data_i  ({fpu_rsp_tag, fpu_rsp_data}),
      .ready_o (fpu_rsp_ready),
      .valid_o (o_vld),
      .data_o  ({o_idx, o_tag, o_data}),
      .ready_i (o_rdy)
   );

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_rsp
      assign rsp_valid[g] = o_vld && (o_idx == SELW'(g));
      assign rsp_data[g]  = o_data;
      assign rsp_tag[g]   = o_tag;
   end

   assign o_rdy = |(rsp_valid & rsp_ready);

   always_ff @(posedge clk) begin
      if (!reset && fpu_rsp_valid && fpu_rsp_ready) assert (idx_ok);
   end

endmodule

// File: doc/vx_fpu_arb.md
VX_FPU_ARB -- requirements
Module: VX_fpu_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing one FPU unit; 1 gives a pass-through with register stages.
REQ-002 SHALL have parameter REQ_DATAW, default 128: packed op_type/fmt/frm/dataa/datab/datac width.
REQ-003 SHALL have parameter RSP_DATAW, default 40: packed result/has_fflags/fflags width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: requester-side tag width; FPU-side tag width is TAG_WIDTH+SELW, where SELW=max(1,clog2(NUM_REQS)).
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQS  per-requester request valid.
REQ-008 SHALL have port req_data  input  NUM_REQS*REQ_DATAW  per-requester request payload.
REQ-009 SHALL have port req_tag  input  NUM_REQS*TAG_WIDTH  per-requester tag.
REQ-010 SHALL have port req_ready  output  NUM_REQS  per-requester accept.
REQ-011 SHALL have ports fpu_req_valid/fpu_req_data/fpu_req_tag  output  1/REQ_DATAW/TAG_WIDTH+SELW  request into the FPU unit; fpu_req_ready  input  1.
REQ-012 SHALL have ports fpu_rsp_valid/fpu_rsp_data/fpu_rsp_tag  input  1/RSP_DATAW/TAG_WIDTH+SELW  response from the FPU unit; fpu_rsp_ready  output  1.
REQ-013 SHALL have ports rsp_valid  output  NUM_REQS; rsp_data  output  NUM_REQS*RSP_DATAW; rsp_tag  output  NUM_REQS*TAG_WIDTH; rsp_ready  input  NUM_REQS.

Function
REQ-014 SHALL transfer on any port only when valid and ready are both high in a cycle; valid/payload, once asserted, held until transfer (outputs and required of inputs).
REQ-015 SHALL grant among asserted req_valid round-robin: highest priority is the index after the last granted index, searching upward with wrap NUM_REQS-1 -> 0.
REQ-016 SHALL advance the round-robin pointer only in a cycle where the granted request transfers; no pointer change on stall.
REQ-017 SHALL assert req_ready[i] only for the granted index i and only when the request stage can accept (empty, or draining this cycle, or skid slot free).
REQ-018 SHALL register the request stage: accepted request appears on fpu_req_* the next cycle (1-cycle latency), with fpu_req_tag = {grant index, req_tag}.
REQ-019 SHALL sustain one request per cycle while fpu_req_ready stays high, using a 2-entry skid buffer so req_ready does not depend combinationally on fpu_req_ready.
REQ-020 SHALL route a response by fpu_rsp_tag upper SELW bits to that requester with rsp_tag = lower TAG_WIDTH bits, registered, 1-cycle latency, via a 2-entry skid buffer.
REQ-021 SHALL drive fpu_rsp_ready high only when the response stage can accept; a stalled destination (rsp_ready low) blocks subsequent responses to all requesters (in-order).
REQ-022 SHALL ignore responses whose index field is >= NUM_REQS by accepting and dropping them (assertion fires in simulation).
REQ-023 SHALL allow a request acceptance and a response delivery in the same cycle without interaction.

Reset
REQ-024 SHALL on reset clear both skid buffers, drive fpu_req_valid=0, all rsp_valid=0, req_ready=0, fpu_rsp_ready=0 during reset, and set the round-robin pointer so index 0 has highest priority next.
REQ-025 SHALL discard in-flight buffered requests/responses on reset mid-operation; first cycle after reset behaves as from power-up.

Structure
REQ-026 SHALL place FPU_REQ_DATAW and FPU_RSP_DATAW constants and request/response packed struct typedefs in VX_fpu_types package.
REQ-027 SHALL implement both 2-entry skid buffers as one sub-module VX_fpu_skid_buf (parameter DATAW), instanced twice.

Verification
REQ-028 SHALL cover: NUM_REQS=4, all req_valid high, fpu_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; fpu_req_tag upper bits match.
REQ-029 SHALL cover: req 2 alone, tag 0x5A -> fpu_req_tag=0x25A one cycle after acceptance.
REQ-030 SHALL cover: fpu_req_ready low 3 cycles with 4 requesters valid -> at most 2 requests buffered, no loss/duplication, pointer unchanged until transfer.
REQ-031 SHALL cover: fpu_rsp_tag=0x1C3 -> rsp_valid[1]=1, rsp_tag=0xC3 next cycle; with rsp_ready[1]=0, fpu_rsp_ready drops after 2 buffered.
REQ-032 SHALL cover: reset asserted with both buffers full -> all valids 0 next cycle; subsequent all-valid request grants index 0 first.
